// File: rtl/div_hilo_ctrl_pkg.sv
// Shared definitions for the EX-stage divide / HI-LO controller.
package div_hilo_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;
  localparam logic [2:0] OP_MFHI = 3'd5;
  localparam logic [2:0] OP_MFLO = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_hilo(input logic [2:0] op);
    return (op >= OP_DIV) && (op <= OP_MFLO);
  endfunction

endpackage

// File: rtl/div_hilo_ctrl.sv
// Issues DIV/DIVU to the iterative divider, stalls EX until the result returns,
// and owns the architectural HI/LO registers (MTHI/MTLO/MFHI/MFLO).
module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] ex_src_a,
  input  logic [DATA_W-1:0] ex_src_b,
  input  logic              ex_flush,
  output logic              ex_stall,
  output logic [DATA_W-1:0] hilo_rdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              div_valid,
  output logic              div_signed,
  output logic [DATA_W-1:0] div_x,
  output logic [DATA_W-1:0] div_y,
  input  logic              div_ready,
  input  logic              div_res_valid,
  input  logic [DATA_W-1:0] div_quot,
  input  logic [DATA_W-1:0] div_rem
);

  state_e            state_q, state_d;
  logic              kill_q, kill_d;
  logic              valid_q, valid_d;
  logic              sgn_q, sgn_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              live;
  logic              mt_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      kill_q  <= 1'b0;
      valid_q <= 1'b0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    sgn_d    = sgn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    x_d      = x_q;
    y_d      = y_q;
    live     = ex_valid && !ex_flush;
    ex_stall = live && ((state_q == ST_REQ) || (state_q == ST_WAIT) ||
                        ((state_q == ST_IDLE) && op_is_div(ex_op)) ||
                        (kill_q && op_is_hilo(ex_op)));
    mt_ok    = live && !ex_stall && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    if (mt_ok && (ex_op == OP_MTHI)) hi_d = ex_src_a;
    if (mt_ok && (ex_op == OP_MTLO)) lo_d = ex_src_a;

    case (state_q)
      ST_IDLE: begin
        if (live && op_is_div(ex_op)) begin
          state_d = ST_REQ;
          x_d     = ex_src_a;
          y_d     = ex_src_b;
          sgn_d   = (ex_op == OP_DIV);
        end
      end
      ST_REQ: begin
        // The request cannot be withdrawn; a flush only marks its result for discard.
        if (ex_flush) kill_d = 1'b1;
        if (div_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_res_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            hi_d    = div_rem;
            lo_d    = div_quot;
            state_d = ST_DONE;
          end
        end else if (ex_flush) begin
          kill_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_REQ);
  end

  assign hilo_rdata = (ex_op == OP_MFHI) ? hi_q :
                      (ex_op == OP_MFLO) ? lo_q : '0;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = (state_q != ST_IDLE);
  assign div_valid  = valid_q;
  assign div_signed = sgn_q;
  assign div_x      = x_q;
  assign div_y      = y_q;

endmodule

// File: doc/div_hilo_ctrl.md
# div_hilo_ctrl

Execute-stage controller that sits directly upstream of the iterative divider. It turns DIV/DIVU instructions in EX into a single request on the divider's valid/ready port and stalls EX until the result returns. It commits quotient/remainder into the architectural HI/LO registers and also services MTHI/MTLO/MFHI/MFLO. Because the divider cannot be aborted, an exception flush during a divide marks the in-flight result for discard rather than cancelling it.

## Interface
Parameters:
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ex_valid  in  1  EX holds a valid instruction.
- ex_op  in  3  0 NOP, 1 DIV, 2 DIVU, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO; 7 treated as NOP.
- ex_src_a  in  DATA_W  rs value (dividend, MTHI/MTLO data).
- ex_src_b  in  DATA_W  rt value (divisor).
- ex_flush  in  1  exception/ERET flush of EX this cycle.
- ex_stall  out  1  hold EX.
- hilo_rdata  out  DATA_W  HI for MFHI, LO for MFLO, else 0.
- hi, lo  out  DATA_W  architectural HI/LO.
- busy  out  1  state != IDLE.
- div_valid  out  1  request to divider, registered.
- div_signed  out  1  1 for DIV, 0 for DIVU.
- div_x, div_y  out  DATA_W  latched dividend/divisor.
- div_ready  in  1  divider accepts request.
- div_res_valid  in  1  one-cycle result pulse.
- div_quot, div_rem  in  DATA_W  result.

## Operation
- States: IDLE, REQ, WAIT, DONE; plus kill flag.
- IDLE: ex_valid & op∈{DIV,DIVU} & !ex_flush → latch operands/signed, → REQ; ex_stall=1.
- REQ: div_valid=1, operands stable until div_ready; div_ready → WAIT. Valid never withdrawn, not even on flush.
- WAIT: div_res_valid & !kill → hi←div_rem, lo←div_quot, → DONE; div_res_valid & kill → IDLE, no write, kill←0.
- DONE: exactly one cycle; ex_stall=0 so the DIV leaves EX; op in EX is not reissued; → IDLE.
- ex_flush while in REQ or WAIT: kill←1 (sticky until discarded result). Flush in IDLE/DONE: no state effect.
- ex_stall = ex_valid & !ex_flush & (state∈{REQ,WAIT} | (state==IDLE & op∈{DIV,DIVU}) | (kill & op∈{DIV,DIVU,MTHI,MTLO,MFHI,MFLO})).
- MTHI/MTLO: write hi/lo at edge when ex_valid & !ex_stall & !ex_flush & state∈{IDLE,DONE}.
- MFHI/MFLO: combinational read of current hi/lo; stalls only while a result is pending.
- Divide-by-zero: commit whatever the divider returns; no trap.
- Unknown result pulse in IDLE/REQ/DONE: ignored.

## Timing
- Reset values: state IDLE, kill 0, hi=lo=0, div_valid 0, div_x=div_y=0, div_signed 0, ex_stall 0, busy 0.
- Request issue: div_valid high the cycle after DIV seen in IDLE.
- Latency to EX release: 1 (IDLE) + accept wait + divider latency + 1 (DONE). HI/LO are visible in the DONE cycle.
- Result pulse and flush in the same WAIT cycle: result is committed (flush arrived too late); kill not set.
- Reset mid-divide: state cleared immediately; any later result pulse is ignored in IDLE.

## Structure
- Shared package: op encoding constants (OP_NOP..OP_MFLO), state enum, DATA_W default.
- Single module, no sub-module; optional hilo_regfile split is not warranted.

## Test plan
- DIV 100/7, divider result after 33 cycles → hi=2, lo=14; ex_stall high until DONE; one div_valid accept.
- DIVU 0xFFFF_FFF0/0x10, div_ready delayed 3 cycles → div_x/div_y held stable; lo=0x0FFF_FFFF, hi=0.
- DIV issued, ex_flush in WAIT, then MTHI 0x55 → MTHI stalls until discarded result; final hi=0x55, lo unchanged.
- MTLO 0xABCD then MFLO next cycle → hilo_rdata=0xABCD, no stall.
- Result pulse coincident with ex_flush in WAIT → hi/lo updated, kill=0.
- Reset asserted in WAIT → all outputs zero that cycle; late div_res_valid leaves hi/lo=0.
